// File: rtl/prod_acc_pkg.sv
// Shared types and sizing for the product accumulator.
package prod_acc_pkg;
   localparam int unsigned ACC_W     = 24;
   localparam int unsigned CNT_W     = 8;
   localparam int unsigned NUM_BYTES = 3;
   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned SEL_W     = 2;
   localparam int unsigned PROD_W    = 16;

   typedef enum logic {
      ACC,
      DRAIN
   } state_e;
endpackage

// File: rtl/prod_acc_ser.sv
// Snapshot register and byte-at-a-time drain with a valid/ready handshake.
module prod_acc_ser
   import prod_acc_pkg::*;
#(
   parameter int unsigned ACC_W = prod_acc_pkg::ACC_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [ACC_W-1:0]  load_data,
   input  logic              byte_ready,
   output logic [BYTE_W-1:0] byte_out,
   output logic [SEL_W-1:0]  byte_sel,
   output logic              byte_valid,
   output logic              done_c
);
   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_BYTES - 1);

   logic [ACC_W-1:0]  snap_q,  snap_d;
   logic [SEL_W-1:0]  sel_q,   sel_d;
   logic              valid_q, valid_d;
   logic [BYTE_W-1:0] out_q,   out_d;
   int unsigned       nxt_idx;

   always_comb begin
      snap_d  = snap_q;
      sel_d   = sel_q;
      valid_d = valid_q;
      out_d   = out_q;
      nxt_idx = 32'(sel_q) + 32'd1;
      done_c  = valid_q & byte_ready & (sel_q == LAST_SEL);
      if (load && !valid_q) begin
         snap_d  = load_data;
         sel_d   = '0;
         valid_d = 1'b1;
         out_d   = load_data[BYTE_W-1:0];
      end else if (valid_q && byte_ready) begin
         if (done_c) begin
            valid_d = 1'b0;
            sel_d   = '0;
            out_d   = '0;
         end else begin
            sel_d = sel_q + SEL_W'(1);
            // next byte is prepared here so byte_out stays a plain register
            out_d = BYTE_W'(snap_q >> (BYTE_W * nxt_idx));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_q  <= '0;
         sel_q   <= '0;
         valid_q <= 1'b0;
         out_q   <= '0;
      end else begin
         snap_q  <= snap_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         out_q   <= out_d;
      end
   end

   assign byte_out   = out_q;
   assign byte_sel   = sel_q;
   assign byte_valid = valid_q;
endmodule

// File: rtl/prod_accumulator.sv
// Sums 16-bit products into a wide accumulator and drains the result bytewise.
module prod_accumulator
   import prod_acc_pkg::*;
#(
   parameter int unsigned ACC_W = prod_acc_pkg::ACC_W,
   parameter int unsigned CNT_W = prod_acc_pkg::CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        prod_low,
   input  logic [7:0]        prod_high,
   input  logic              prod_valid,
   output logic              prod_ready,
   input  logic              clear,
   input  logic              dump,
   output logic [7:0]        byte_out,
   output logic [1:0]        byte_sel,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic              overflow,
   output logic [CNT_W-1:0]  term_count,
   output logic              busy
);
   state_e            state_q, state_d;
   logic [ACC_W-1:0]  acc_q,   acc_d;
   logic              ovf_q,   ovf_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic              busy_q,  busy_d;

   logic              hs;
   logic [ACC_W:0]    sum;
   logic [ACC_W-1:0]  prod_ext;
   logic [CNT_W-1:0]  cnt_inc;
   logic              snap_load;
   logic [ACC_W-1:0]  snap_data;
   logic              ser_done;

   assign prod_ready = ~busy_q;
   assign hs         = prod_valid & prod_ready;
   assign prod_ext   = ACC_W'({prod_high, prod_low});
   assign sum        = {1'b0, acc_q} + {1'b0, prod_ext};
   assign cnt_inc    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      ovf_d     = ovf_q;
      cnt_d     = cnt_q;
      snap_load = 1'b0;
      snap_data = acc_q;
      unique case (state_q)
         ACC: begin
            if (dump) begin
               // dump wins over clear and captures a same-cycle product
               snap_load = 1'b1;
               snap_data = hs ? sum[ACC_W-1:0] : acc_q;
               acc_d     = '0;
               ovf_d     = 1'b0;
               cnt_d     = '0;
               state_d   = DRAIN;
            end else if (clear) begin
               acc_d = hs ? prod_ext : '0;
               ovf_d = 1'b0;
               cnt_d = hs ? CNT_W'(1) : '0;
            end else if (hs) begin
               acc_d = sum[ACC_W-1:0];
               ovf_d = ovf_q | sum[ACC_W];
               cnt_d = cnt_inc;
            end
         end
         DRAIN: begin
            if (ser_done) state_d = ACC;
         end
         default: state_d = ACC;
      endcase
      busy_d = (state_d == DRAIN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACC;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   prod_acc_ser #(.ACC_W(ACC_W)) u_ser (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (snap_load),
      .load_data  (snap_data),
      .byte_ready (byte_ready),
      .byte_out   (byte_out),
      .byte_sel   (byte_sel),
      .byte_valid (byte_valid),
      .done_c     (ser_done)
   );

   assign overflow   = ovf_q;
   assign term_count = cnt_q;
   assign busy       = busy_q;
endmodule

// File: tb/tb_prod_accumulator.sv
// Scoreboard bench for prod_accumulator: model predicts drained bytes and flags.
module tb_prod_accumulator;
   logic       clk, rst_n;
   logic [7:0] prod_low, prod_high;
   logic       prod_valid, prod_ready, clear, dump;
   logic [7:0] byte_out;
   logic [1:0] byte_sel;
   logic       byte_valid, byte_ready, overflow, busy;
   logic [7:0] term_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] b;
      logic [1:0] s;
   } exp_t;
   exp_t q[$];

   logic [23:0] m_acc;
   logic        m_ovf;
   logic [7:0]  m_cnt;

   prod_accumulator dut (
      .clk(clk), .rst_n(rst_n), .prod_low(prod_low), .prod_high(prod_high),
      .prod_valid(prod_valid), .prod_ready(prod_ready), .clear(clear), .dump(dump),
      .byte_out(byte_out), .byte_sel(byte_sel), .byte_valid(byte_valid),
      .byte_ready(byte_ready), .overflow(overflow), .term_count(term_count), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push_bytes(input logic [23:0] v);
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         e.b = 8'(v >> (8 * i));
         e.s = 2'(i);
         q.push_back(e);
      end
   endtask

   // one cycle in ACC with the model updated alongside
   task automatic cycle(input logic v, input logic [15:0] p, input logic c, input logic d);
      logic [24:0] s;
      prod_valid = v; {prod_high, prod_low} = p; clear = c; dump = d;
      if (v) begin
         checks++;
         if (prod_ready !== 1'b1) begin
            errors++; $display("FAIL acc_ready got %b want 1", prod_ready);
         end
      end
      s = {1'b0, m_acc} + {9'd0, (v ? p : 16'd0)};
      if (d) begin
         push_bytes(s[23:0]);
         m_acc = '0; m_ovf = 1'b0; m_cnt = '0;
      end else if (c) begin
         m_acc = v ? {8'd0, p} : 24'd0; m_ovf = 1'b0; m_cnt = v ? 8'd1 : 8'd0;
      end else if (v) begin
         m_acc = s[23:0]; m_ovf = m_ovf | s[24];
         if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end
      @(posedge clk); #1;
      prod_valid = 1'b0; clear = 1'b0; dump = 1'b0;
   endtask

   task automatic check_status(input string name);
      checks++;
      if (term_count !== m_cnt || overflow !== m_ovf) begin
         errors++;
         $display("FAIL %s term_count/overflow got %0d/%b want %0d/%b",
                  name, term_count, overflow, m_cnt, m_ovf);
      end
   endtask

   task automatic check_idle(input string name);
      checks++;
      if (byte_valid !== 1'b0 || busy !== 1'b0 || prod_ready !== 1'b1 ||
          byte_sel !== 2'd0 || byte_out !== 8'h00) begin
         errors++;
         $display("FAIL %s idle got v=%b busy=%b rdy=%b sel=%0d out=%h want 0 0 1 0 00",
                  name, byte_valid, busy, prod_ready, byte_sel, byte_out);
      end
   endtask

   // drains the queued bytes; optional stall on one byte, optional stray inputs during stall
   task automatic run_drain(input string name, input int stall_sel, input int stall_len,
                            input bit poke);
      int   stalls = 0;
      int   budget = 0;
      bit   held = 0;
      logic [7:0] held_b;
      logic [1:0] held_s;
      exp_t e;
      while (q.size() != 0 && budget < 60) begin
         budget++;
         checks++;
         if (byte_valid !== 1'b1 || busy !== 1'b1 || prod_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s drain_flags got v=%b busy=%b rdy=%b want 1 1 0",
                     name, byte_valid, busy, prod_ready);
         end
         if (held) begin
            checks++;
            if (byte_out !== held_b || byte_sel !== held_s) begin
               errors++;
               $display("FAIL %s stable got %h/%0d want %h/%0d",
                        name, byte_out, byte_sel, held_b, held_s);
            end
         end
         if (int'(byte_sel) == stall_sel && stalls < stall_len) begin
            byte_ready = 1'b0; stalls++; held = 1; held_b = byte_out; held_s = byte_sel;
            if (poke) begin
               clear = 1'b1; dump = 1'b1; prod_valid = 1'b1; {prod_high, prod_low} = 16'hFFFF;
            end
         end else begin
            byte_ready = 1'b1; held = 0;
            clear = 1'b0; dump = 1'b0; prod_valid = 1'b0;
            e = q.pop_front();
            checks++;
            if (byte_out !== e.b || byte_sel !== e.s) begin
               errors++;
               $display("FAIL %s byte got %h sel %0d want %h sel %0d",
                        name, byte_out, byte_sel, e.b, e.s);
            end
         end
         @(posedge clk); #1;
      end
      byte_ready = 1'b0; clear = 1'b0; dump = 1'b0; prod_valid = 1'b0;
      checks++;
      if (q.size() != 0) begin
         errors++; $display("FAIL %s timeout got %0d bytes left want 0", name, q.size());
         q.delete();
      end
      check_idle({name, "_exit"});
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      check_idle("reset");
      m_acc = '0; m_ovf = 1'b0; m_cnt = '0;
      check_status("reset");
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check_idle("reset_release");
   endtask

   task automatic test_basic;
      for (int i = 0; i < 3; i++) cycle(1'b1, 16'hFE01, 1'b0, 1'b0);
      check_status("basic_cnt3");
      cycle(1'b0, 16'h0, 1'b0, 1'b1);
      check_status("basic_after_dump");
      run_drain("basic", -1, 0, 1'b0);
   endtask

   task automatic test_overflow;
      for (int i = 1; i <= 259; i++) begin
         cycle(1'b1, 16'hFE01, 1'b0, 1'b0);
         if (i == 255) check_status("ovf_cnt255");
         if (i == 258) check_status("ovf_pre");
      end
      check_status("ovf_set");
      cycle(1'b0, 16'h0, 1'b0, 1'b1);
      check_status("ovf_cleared");
      run_drain("ovf", -1, 0, 1'b0);
   endtask

   task automatic test_dump_with_product;
      cycle(1'b1, 16'h0100, 1'b0, 1'b0);
      cycle(1'b1, 16'h0010, 1'b0, 1'b1);
      run_drain("dump_prod", -1, 0, 1'b0);
   endtask

   task automatic test_stall;
      cycle(1'b1, 16'hBEEF, 1'b0, 1'b0);
      cycle(1'b1, 16'h1357, 1'b0, 1'b0);
      cycle(1'b0, 16'h0, 1'b0, 1'b1);
      run_drain("stall", 1, 5, 1'b1);
      check_status("stall_ignored");
   endtask

   task automatic test_clear;
      cycle(1'b1, 16'h7777, 1'b0, 1'b0);
      cycle(1'b1, 16'h1234, 1'b1, 1'b0);
      check_status("clear_prod");
      cycle(1'b0, 16'h0, 1'b0, 1'b1);
      run_drain("clear_prod", -1, 0, 1'b0);
      cycle(1'b1, 16'h0100, 1'b0, 1'b0);
      cycle(1'b1, 16'h0100, 1'b0, 1'b0);
      cycle(1'b0, 16'h0, 1'b1, 1'b1);
      run_drain("clear_dump", -1, 0, 1'b0);
   endtask

   task automatic test_reset_mid_drain;
      cycle(1'b1, 16'hABCD, 1'b0, 1'b0);
      cycle(1'b0, 16'h0, 1'b0, 1'b1);
      byte_ready = 1'b1;
      @(posedge clk); #1;
      byte_ready = 1'b0;
      checks++;
      if (byte_sel !== 2'd1 || byte_valid !== 1'b1) begin
         errors++; $display("FAIL mid_pre got sel=%0d v=%b want 1 1", byte_sel, byte_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      q.delete();
      m_acc = '0; m_ovf = 1'b0; m_cnt = '0;
      checks++;
      if (byte_valid !== 1'b0 || busy !== 1'b0 || byte_sel !== 2'd0 ||
          term_count !== 8'd0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got v=%b busy=%b sel=%0d cnt=%0d ovf=%b want 0 0 0 0 0",
                  byte_valid, busy, byte_sel, term_count, overflow);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check_idle("mid_release");
      cycle(1'b1, 16'h0005, 1'b0, 1'b0);
      cycle(1'b0, 16'h0, 1'b0, 1'b1);
      run_drain("post_reset", -1, 0, 1'b0);
   endtask

   initial begin
      prod_valid = 1'b0; prod_low = '0; prod_high = '0;
      clear = 1'b0; dump = 1'b0; byte_ready = 1'b0;
      test_reset();
      test_basic();
      test_overflow();
      test_dump_with_product();
      test_stall();
      test_clear();
      test_reset_mid_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
